lcd_time_display: RTL

LCD_TIME_DISPLAY -- requirements
Module: lcd_time_display

---
 rtl/lcd_time_display.sv | 199 +++++++++++++++++++
 1 files changed

// File: rtl/lcd_time_display.sv
// Character LCD driver that shows "TIME hh:mm:ss" on line 1 and weekday/alarm on line 2.
// All bus activity is paced in fixed steps of STEP_CYC clocks, with one strobe pulse per active step.
module lcd_time_display #(
    parameter int STEP_CYC  = 5400,
    parameter int E_HIGH    = 20,
    parameter int INIT_WAIT = 30
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [4:0] hour,
    input  logic [5:0] min,
    input  logic [5:0] sec,
    input  logic [2:0] day_cnt,
    input  logic       enable,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_data,
    output logic       init_done,
    output logic       frame_done
);

    localparam int CW      = (STEP_CYC > 1) ? $clog2(STEP_CYC) : 1;
    localparam int IDX_LIM = (INIT_WAIT > 17) ? INIT_WAIT : 17;
    localparam int IW      = $clog2(IDX_LIM + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(STEP_CYC - 1);
    localparam logic [CW-1:0] E_LAST    = CW'(E_HIGH);
    localparam logic [IW-1:0] PW_LAST   = IW'(INIT_WAIT - 1);
    localparam logic [IW-1:0] INIT_LAST = IW'(4);
    localparam logic [IW-1:0] LINE_LAST = IW'(16);

    localparam logic [1:0] PWR_WAIT = 2'd0;
    localparam logic [1:0] INIT     = 2'd1;
    localparam logic [1:0] L1       = 2'd2;
    localparam logic [1:0] L2       = 2'd3;

    logic [CW-1:0] cnt;
    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [4:0]    s_hour;
    logic [5:0]    s_min;
    logic [5:0]    s_sec;
    logic [2:0]    s_day;
    logic          s_en;
    logic          step_end;
    logic          step_active;
    logic [3:0]    pos;
    logic [7:0]    l1_char;
    logic [7:0]    l2_char;
    logic [23:0]   day_name;

    function automatic logic [7:0] tens(input logic [5:0] v);
        return 8'h30 + 8'(v / 6'd10);
    endfunction

    function automatic logic [7:0] ones(input logic [5:0] v);
        return 8'h30 + 8'(v % 6'd10);
    endfunction

    assign step_end = (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt    <= '0;
            state  <= PWR_WAIT;
            idx    <= '0;
            s_hour <= '0;
            s_min  <= '0;
            s_sec  <= '0;
            s_day  <= '0;
            s_en   <= 1'b0;
        end else begin
            cnt <= step_end ? '0 : cnt + 1'b1;
            // Snapshots are taken during the address-command step so a whole line is tear-free.
            if (cnt == '0 && state == L1 && idx == '0) begin
                s_hour <= hour;
                s_min  <= min;
                s_sec  <= sec;
            end
            if (cnt == '0 && state == L2 && idx == '0) begin
                s_day <= day_cnt;
                s_en  <= enable;
            end
            if (step_end) begin
                case (state)
                    PWR_WAIT: if (idx == PW_LAST) begin
                        state <= INIT;
                        idx   <= '0;
                    end else idx <= idx + 1'b1;
                    INIT: if (idx == INIT_LAST) begin
                        state <= L1;
                        idx   <= '0;
                    end else idx <= idx + 1'b1;
                    L1: if (idx == LINE_LAST) begin
                        state <= L2;
                        idx   <= '0;
                    end else idx <= idx + 1'b1;
                    default: if (idx == LINE_LAST) begin
                        state <= L1;
                        idx   <= '0;
                    end else idx <= idx + 1'b1;
                endcase
            end
        end
    end

    assign pos = 4'(idx - 1'b1);

    always_comb begin
        case (s_day)
            3'd0:    day_name = "SUN";
            3'd1:    day_name = "MON";
            3'd2:    day_name = "TUE";
            3'd3:    day_name = "WED";
            3'd4:    day_name = "THU";
            3'd5:    day_name = "FRI";
            3'd6:    day_name = "SAT";
            default: day_name = "---";
        endcase
    end

    always_comb begin
        l1_char = " ";
        case (pos)
            4'd0:    l1_char = "T";
            4'd1:    l1_char = "I";
            4'd2:    l1_char = "M";
            4'd3:    l1_char = "E";
            4'd5:    l1_char = tens({1'b0, s_hour});
            4'd6:    l1_char = ones({1'b0, s_hour});
            4'd7:    l1_char = ":";
            4'd8:    l1_char = tens(s_min);
            4'd9:    l1_char = ones(s_min);
            4'd10:   l1_char = ":";
            4'd11:   l1_char = tens(s_sec);
            4'd12:   l1_char = ones(s_sec);
            default: l1_char = " ";
        endcase
    end

    always_comb begin
        l2_char = " ";
        case (pos)
            4'd0:    l2_char = day_name[23:16];
            4'd1:    l2_char = day_name[15:8];
            4'd2:    l2_char = day_name[7:0];
            4'd4:    l2_char = s_en ? "A" : " ";
            4'd5:    l2_char = s_en ? "L" : " ";
            4'd6:    l2_char = s_en ? "A" : " ";
            4'd7:    l2_char = s_en ? "R" : " ";
            4'd8:    l2_char = s_en ? "M" : " ";
            default: l2_char = " ";
        endcase
    end

    // Bus value is decoded from registered state only, so it can change solely at a step boundary.
    always_comb begin
        step_active = 1'b0;
        lcd_rs      = 1'b0;
        lcd_data    = 8'h00;
        case (state)
            INIT: begin
                if (idx < INIT_LAST) begin
                    step_active = 1'b1;
                    case (idx[1:0])
                        2'd0:    lcd_data = 8'h38;
                        2'd1:    lcd_data = 8'h0C;
                        2'd2:    lcd_data = 8'h06;
                        default: lcd_data = 8'h01;
                    endcase
                end
            end
            L1: begin
                step_active = 1'b1;
                if (idx == '0) lcd_data = 8'h80;
                else begin
                    lcd_rs   = 1'b1;
                    lcd_data = l1_char;
                end
            end
            L2: begin
                step_active = 1'b1;
                if (idx == '0) lcd_data = 8'hC0;
                else begin
                    lcd_rs   = 1'b1;
                    lcd_data = l2_char;
                end
            end
            default: ;
        endcase
    end

    assign lcd_e      = step_active && (cnt != '0) && (cnt <= E_LAST);
    assign lcd_rw     = 1'b0;
    assign init_done  = (state == L1) || (state == L2);
    assign frame_done = (state == L2) && (idx == LINE_LAST) && step_end;

endmodule
